fir_decim_ser: RTL
==================

Name: fir_decim_ser

Overview:
- Downstream neighbour of the 8-channel decimate-by-4 FIR.
- Accepts the FIR's packed 192-bit output word (8 × 24-bit channels, strobed by a one-cycle valid) and buffers whole words in a small FIFO.
- Serializes each word one channel per clock onto a 24-bit valid/ready stream, with channel index and last-channel marker, for the next processing or packetizing stage.
- Detects and flags input words lost to backpressure.

Parameters:
- NCH, 8: channels per input word; channel k occupies id[24k+23:24k].
- NB, 24: bits per channel sample.
- DEPTH, 4: FIFO depth in whole input words; power of 2, minimum 2.

Ports:
- c  input  1  clock; all logic on rising edge.
- reset_n  input  1  reset, synchronous, active-low.
- id  input  NCH*NB (192)  packed input word from the FIR.
- iv  input  1  input valid; one-cycle strobe, id sampled on the same edge.
- od  output  NB (24)  serialized sample.
- och  output  3 ($clog2(NCH))  channel index of od.
- olast  output  1  high when och == NCH-1 and ov is high.
- ov  output  1  od/och/olast valid.
- ordy  input  1  downstream ready; transfer occurs when ov && ordy.
- overflow  output  1  sticky flag: at least one input word was dropped.
- level  output  $clog2(DEPTH)+1  number of words held in the FIFO, excluding the output stage.

Behaviour:
- Reset (reset_n low at a rising edge):
  - FIFO is emptied: level=0.
  - ov=0, och=0, olast=0, od=0, overflow=0.
  - Reset applies mid-word: any partially sent word is discarded, with no completion of its remaining channels.
  - While reset_n is low, iv is ignored.
- Storage: FIFO of DEPTH × 192-bit words, plus one 192-bit output holding register that is indexed by och.
- Write side: on an edge with iv=1:
  - If level < DEPTH, the word is pushed.
  - If level == DEPTH and no pop occurs on the same edge, the word is dropped and overflow is set to 1. It stays 1 until reset.
  - If level == DEPTH and a pop occurs on the same edge, the write is accepted and level stays DEPTH.
- Output stage states:
  - IDLE (ov=0).
  - BUSY (ov=1, presenting channel och of the held word).
- IDLE → BUSY:
  - On any edge where the FIFO is non-empty, the oldest word is popped into the holding register, och=0, ov=1.
  - An empty block receiving iv at edge k shows ov=1 with och=0 after edge k+1, i.e. 2-cycle latency from the iv cycle to first valid output.
- BUSY, transfer with och < NCH-1: och increments and od updates to the next channel on the following cycle.
- BUSY, transfer with och == NCH-1 (olast=1):
  - If the FIFO is non-empty, the next word is popped on the same edge, och=0, ov stays 1. There is no bubble between words.
  - Otherwise the block returns to IDLE and ov=0.
- BUSY, no transfer (ordy=0): od, och, olast and ov are held stable. The AXI-style rule applies: once asserted, ov does not drop without a transfer.
- Ordering:
  - Words are emitted in arrival order.
  - Within a word, channels are emitted 0..NCH-1, with od = id[24·och+23 : 24·och] of that word.
- Data passes through unmodified. There is no arithmetic, rounding or sign change.
- level counts FIFO words only:
  - It increments on push without pop and decrements on pop without push.
  - It is unchanged on simultaneous push and pop, and on no push and no pop.
- Throughput: with ordy held high, the block drains one word per NCH clocks. The upstream FIR emits one word per 16 clocks, so under continuous ready the FIFO never exceeds one word.
- olast = ov && (och == NCH-1), registered alongside od.

Test Plan:
- Basic path:
  - Stimulus: after reset, ordy=1; a single iv with id lanes k = 0x100000+k (k=0..7).
  - Required: ov rises 2 clocks after iv; od = 0x100000..0x100007 on consecutive cycles with och 0..7; olast only on the 8th; then ov=0; overflow=0.
- Back-to-back words:
  - Stimulus: two iv strobes 8 clocks apart, ordy=1.
  - Required: 16 consecutive ov cycles with no gap; word 1 channels follow word 0 channel 7 directly; level never exceeds 1.
- Backpressure stall:
  - Stimulus: ordy low for 5 cycles while och=3.
  - Required: od, och=3 and ov=1 held unchanged for all 5 cycles; channel 4 is presented on the cycle after ordy returns high.
- Overflow:
  - Stimulus: ordy=0; 6 iv strobes with DEPTH=4.
  - Required: 1 word in the output stage and level=4; the 6th word is dropped and overflow=1; after releasing ordy, exactly 5 words (40 samples) emerge in order and overflow stays 1.
- Full with simultaneous pop:
  - Stimulus: level=4; ordy=1; iv arrives on the same edge as an olast transfer.
  - Required: word accepted; level stays 4; overflow stays 0.
- Reset mid-word:
  - Stimulus: reset_n low for 1 cycle while och=5 and level=2.
  - Required: next cycle ov=0, och=0, level=0, overflow=0; a subsequent iv behaves exactly as in the basic path scenario.

Source files
------------

// File: rtl/fir_decim_ser.sv
// fir_decim_ser
// Serializer placed after the 8-channel decimate-by-4 FIR. Whole packed
// output words from the FIR are buffered in a small word FIFO, then emitted
// one channel per clock on a valid/ready stream. Words that arrive while the
// FIFO is full, with no pop on the same edge, are dropped and flagged.
//
// Ports:
//   c         clock, all logic on the rising edge
//   reset_n   synchronous active-low reset
//   id        packed input word, channel k at id[NB*k +: NB]
//   iv        one-cycle input strobe, id sampled on the same edge
//   od        serialized sample
//   och       channel index of od
//   olast     high while the last channel of a word is presented
//   ov        od/och/olast valid
//   ordy      downstream ready; a transfer happens when ov && ordy
//   overflow  sticky flag, set when an input word has been dropped
//   level     words held in the FIFO, not counting the output stage
module fir_decim_ser #(
  parameter int NCH   = 8,
  parameter int NB    = 24,
  parameter int DEPTH = 4
) (
  input  logic                     c,
  input  logic                     reset_n,
  input  logic [NCH*NB-1:0]        id,
  input  logic                     iv,
  output logic [NB-1:0]            od,
  output logic [$clog2(NCH)-1:0]   och,
  output logic                     olast,
  output logic                     ov,
  input  logic                     ordy,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int CW = $clog2(NCH);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int WW = NCH * NB;
  localparam logic [LW-1:0] FULL   = LW'(DEPTH);
  localparam logic [CW-1:0] LASTCH = CW'(NCH - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [WW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;
  logic [WW-1:0]   hold;
  logic            fifo_ne;
  logic            xfer;
  logic            pop;
  logic            push;
  logic            drop;
  logic            advance;
  logic            finish;

  assign ov = (state == BUSY);

  // Output-stage sequencing. A pop happens whenever the stage is idle with
  // data waiting, or when the last channel transfers and another word is
  // queued, which gives back-to-back words with no bubble. A full FIFO still
  // accepts a write on an edge that also pops.
  always_comb begin
    state_nxt = state;
    fifo_ne   = (level != '0);
    xfer      = ov && ordy;
    pop       = 1'b0;
    advance   = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (fifo_ne) begin
          pop       = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (xfer) begin
          if (och == LASTCH) begin
            if (fifo_ne) begin
              pop = 1'b1;
            end else begin
              finish    = 1'b1;
              state_nxt = IDLE;
            end
          end else begin
            advance = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    push = iv && ((level != FULL) || pop);
    drop = iv && (level == FULL) && !pop;
  end

  always_ff @(posedge c) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Word storage has no reset; only the pointers and level define contents.
  always_ff @(posedge c) begin
    if (reset_n && push) begin
      mem[wptr] <= id;
    end
  end

  // The holding register shifts down one channel per transfer, so the next
  // sample to present always sits in the second lane. och tracks the lane
  // index of the original word.
  always_ff @(posedge c) begin
    if (!reset_n) begin
      wptr     <= '0;
      rptr     <= '0;
      level    <= '0;
      overflow <= 1'b0;
      hold     <= '0;
      od       <= '0;
      och      <= '0;
      olast    <= 1'b0;
    end else begin
      if (push) begin
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (drop) begin
        overflow <= 1'b1;
      end
      if (pop) begin
        hold  <= mem[rptr];
        od    <= mem[rptr][NB-1:0];
        och   <= '0;
        olast <= (LASTCH == '0);
      end else if (advance) begin
        hold  <= hold >> NB;
        od    <= hold[2*NB-1:NB];
        och   <= och + 1'b1;
        olast <= ((och + 1'b1) == LASTCH);
      end else if (finish) begin
        och   <= '0;
        olast <= 1'b0;
      end
    end
  end

endmodule
